// File: rtl/axi_slave_pkg.sv
// Shared types and width defaults for the AXI memory slave.
package axi_slave_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned ID_WIDTH_DEF   = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a master and the memory slave.
interface axi_mem_slave_if
  import axi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned ID_WIDTH   = ID_WIDTH_DEF
) ();

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_addr_gen.sv
// Combinational AXI beat-to-beat address stepping plus burst-parameter error flag.
module axi_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_len_ok;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size;
    incr_addr   = addr + step;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    // Wrap container is (len+1) beats of 2^size bytes; mask selects the offset inside it.
    wrap_mask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr   = incr_addr;
    err         = (size > 3'd2);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
        if (wrap_len_ok) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        else             err = 1'b1;
      end
      BURST_RSVD:  err = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent write and read FSMs over a word-addressed array.
module axi_mem_slave
  import axi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned ID_WIDTH   = ID_WIDTH_DEF,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input logic            clk,
  input logic            reset,
  axi_mem_slave_if.slave s
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  wstate_e               w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;

  rstate_e               r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_gen_err;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range, w_last_beat, w_err_beat, mem_we;

  logic [ADDR_WIDTH-1:0] r_gen_addr, r_next_addr, rd_addr;
  logic [7:0]            r_gen_len;
  logic [2:0]            r_gen_size;
  logic [1:0]            r_gen_burst;
  logic                  r_gen_err;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            rd_resp;

  logic unused_sideband;
  assign unused_sideband = ^{s.awlock, s.awcache, s.awprot, s.arlock, s.arcache, s.arprot};

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_addr_gen (
    .addr(w_addr_q), .len(w_len_q), .size(w_size_q), .burst(w_burst_q),
    .next_addr(w_next_addr), .err(w_gen_err)
  );

  // While idle the read generator looks at the AR channel so the first beat's error is known at accept.
  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_addr_gen (
    .addr(r_gen_addr), .len(r_gen_len), .size(r_gen_size), .burst(r_gen_burst),
    .next_addr(r_next_addr), .err(r_gen_err)
  );

  always_comb begin
    w_state_d   = w_state_q;
    aw_id_d     = aw_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_size_d    = w_size_q;
    w_burst_d   = w_burst_q;
    w_cnt_d     = w_cnt_q;
    w_err_d     = w_err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we      = 1'b0;
    w_idx       = w_addr_q[ADDR_WIDTH-1:2];
    w_in_range  = 32'(w_idx) < MEM_DEPTH;
    w_last_beat = (w_cnt_q == w_len_q);
    w_err_beat  = w_err_q | w_gen_err | ~w_in_range | (s.wlast != w_last_beat);
    unique case (w_state_q)
      W_IDLE: begin
        if (s.awvalid) begin
          aw_id_d   = s.awid;
          w_addr_d  = s.awaddr;
          w_len_d   = s.awlen;
          w_size_d  = s.awsize;
          w_burst_d = s.awburst;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s.wvalid) begin
          mem_we   = w_in_range;
          w_err_d  = w_err_beat;
          w_addr_d = w_next_addr;
          w_cnt_d  = 8'(w_cnt_q + 8'd1);
          if (w_last_beat) begin
            bid_d     = aw_id_q;
            bresp_d   = w_err_beat ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_size_d    = r_size_q;
    r_burst_d   = r_burst_q;
    r_cnt_d     = r_cnt_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    r_gen_addr  = (r_state_q == R_IDLE) ? s.araddr  : r_addr_q;
    r_gen_len   = (r_state_q == R_IDLE) ? s.arlen   : r_len_q;
    r_gen_size  = (r_state_q == R_IDLE) ? s.arsize  : r_size_q;
    r_gen_burst = (r_state_q == R_IDLE) ? s.arburst : r_burst_q;
    rd_addr     = (r_state_q == R_IDLE) ? s.araddr  : r_next_addr;
    rd_idx      = rd_addr[ADDR_WIDTH-1:2];
    rd_in_range = 32'(rd_idx) < MEM_DEPTH;
    rd_word     = rd_in_range ? mem_q[rd_idx[MEM_AW-1:0]] : '0;
    rd_resp     = (r_gen_err || !rd_in_range) ? RESP_SLVERR : RESP_OKAY;
    unique case (r_state_q)
      R_IDLE: begin
        if (s.arvalid) begin
          r_addr_d  = s.araddr;
          r_len_d   = s.arlen;
          r_size_d  = s.arsize;
          r_burst_d = s.arburst;
          r_cnt_d   = '0;
          rid_d     = s.arid;
          rdata_d   = rd_word;
          rresp_d   = rd_resp;
          rlast_d   = (s.arlen == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s.rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_next_addr;
            r_cnt_d  = 8'(r_cnt_q + 8'd1);
            rdata_d  = rd_word;
            rresp_d  = rd_resp;
            rlast_d  = (8'(r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      aw_id_q   <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_id_q   <= aw_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Storage is never cleared; a beat presented during reset is discarded.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (s.wstrb[i]) mem_q[w_idx[MEM_AW-1:0]][8*i +: 8] <= s.wdata[8*i +: 8];
      end
    end
  end

  assign s.awready = (w_state_q == W_IDLE);
  assign s.wready  = (w_state_q == W_DATA);
  assign s.bvalid  = (w_state_q == W_RESP);
  assign s.bid     = bid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = (r_state_q == R_IDLE);
  assign s.rvalid  = (r_state_q == R_DATA);
  assign s.rid     = rid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.rlast   = rlast_q;

endmodule
